regfile_commit_sequencer: RTL

- Sits between the ROB commit stage and the regfile's single commit write port.
- Accepts up to two in-order commits per cycle (lane 0 older than lane 1) and buffers them in a small FIFO.
- Drains the FIFO one entry per cycle into the regfile write port.
- Forwards buffered, not-yet-written values to dispatch operand reads so dispatch never reads a stale GPR.

---
 rtl/regfile_commit_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/regfile_commit_sequencer.sv
// Commit sequencer: buffers up to two in-order ROB commits per cycle, drains one per
// cycle into the regfile write port, and forwards pending values to dispatch reads.

module regfile_commit_sequencer_fwd #(
  parameter int N        = 5,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 64,
  parameter int ZERO_IDX = 31
) (
  input  logic [N-1:0]             cand_vld,
  input  logic [N-1:0][IDX_W-1:0]  cand_idx,
  input  logic [N-1:0][DATA_W-1:0] cand_val,
  input  logic [IDX_W-1:0]         op,
  output logic                     hit,
  output logic [DATA_W-1:0]        value
);
  // Candidates are ordered oldest first, so the last match is the youngest.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_vld[i] && cand_idx[i] == op && op != IDX_W'(ZERO_IDX)) begin
        hit   = 1'b1;
        value = cand_val[i];
      end
    end
  end
endmodule

module regfile_commit_sequencer #(
  parameter int DATA_W   = 64,
  parameter int IDX_W    = 5,
  parameter int DEPTH    = 4,
  parameter int ZERO_IDX = 31
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_c0_valid,
  input  logic [IDX_W-1:0]          in_c0_index,
  input  logic [DATA_W-1:0]         in_c0_value,
  input  logic                      in_c1_valid,
  input  logic [IDX_W-1:0]          in_c1_index,
  input  logic [DATA_W-1:0]         in_c1_value,
  output logic                      out_c_ready,
  output logic                      out_rf_should_commit,
  output logic [IDX_W-1:0]          out_rf_index,
  output logic [DATA_W-1:0]         out_rf_value,
  input  logic [IDX_W-1:0]          in_d_op1,
  input  logic [IDX_W-1:0]          in_d_op2,
  output logic                      out_fwd_op1_hit,
  output logic [DATA_W-1:0]         out_fwd_op1_value,
  output logic                      out_fwd_op2_hit,
  output logic [DATA_W-1:0]         out_fwd_op2_value,
  output logic [$clog2(DEPTH):0]    out_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head, tail, tail1;
  logic [CW-1:0]   count;
  logic            ok0, ok1, deq;
  logic [1:0]      enq_n;

  assign out_c_ready = (count <= CW'(DEPTH - 2));
  assign out_count   = count;

  // Zero-register commits are dropped here so they never occupy a slot.
  assign ok0   = out_c_ready && in_c0_valid && (in_c0_index != IDX_W'(ZERO_IDX));
  assign ok1   = out_c_ready && in_c1_valid && (in_c1_index != IDX_W'(ZERO_IDX));
  assign enq_n = {1'b0, ok0} + {1'b0, ok1};
  assign deq   = (count != '0);
  assign tail1 = tail + PW'(ok0);

  always_ff @(posedge in_clk) begin
    if (ok0) mem[tail]  <= '{idx: in_c0_index, val: in_c0_value};
    if (ok1) mem[tail1] <= '{idx: in_c1_index, val: in_c1_value};
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      out_rf_should_commit <= 1'b0;
      out_rf_index         <= '0;
      out_rf_value         <= '0;
    end else begin
      tail  <= tail + PW'(enq_n);
      count <= count + CW'(enq_n) - CW'(deq);
      out_rf_should_commit <= deq;
      if (deq) begin
        head         <= head + PW'(1);
        out_rf_index <= mem[head].idx;
        out_rf_value <= mem[head].val;
      end
    end
  end

  // Slot 0 is the output register (oldest); slots 1..DEPTH walk head toward tail.
  logic [DEPTH:0]             cand_vld;
  logic [DEPTH:0][IDX_W-1:0]  cand_idx;
  logic [DEPTH:0][DATA_W-1:0] cand_val;

  always_comb begin
    cand_vld    = '0;
    cand_idx    = '0;
    cand_val    = '0;
    cand_vld[0] = out_rf_should_commit;
    cand_idx[0] = out_rf_index;
    cand_val[0] = out_rf_value;
    for (int i = 0; i < DEPTH; i++) begin
      cand_vld[i+1] = (CW'(i) < count);
      cand_idx[i+1] = mem[head + PW'(i)].idx;
      cand_val[i+1] = mem[head + PW'(i)].val;
    end
  end

  logic [1:0][IDX_W-1:0]  ops;
  logic [1:0]             hits;
  logic [1:0][DATA_W-1:0] vals;

  assign ops = {in_d_op2, in_d_op1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    regfile_commit_sequencer_fwd #(
      .N(DEPTH + 1), .IDX_W(IDX_W), .DATA_W(DATA_W), .ZERO_IDX(ZERO_IDX)
    ) u_fwd (
      .cand_vld (cand_vld),
      .cand_idx (cand_idx),
      .cand_val (cand_val),
      .op       (ops[g]),
      .hit      (hits[g]),
      .value    (vals[g])
    );
  end

  assign out_fwd_op1_hit   = hits[0];
  assign out_fwd_op1_value = vals[0];
  assign out_fwd_op2_hit   = hits[1];
  assign out_fwd_op2_value = vals[1];
endmodule
